branch_resolve_queue: RTL

//  In-order queue of in-flight branch predictions, downstream of the BHT.
//  - Captures each BHT prediction with its PC; pairs it with the later branch outcome.
//  - Issues the training update (pc, taken) back to the BHT and detects mispredicts.
//  - Flushes younger entries on a mispredict and keeps saturating accuracy counters.

---
 rtl/branch_resolve_queue.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - in-order queue pairing BHT predictions with branch outcomes
//
// Purpose:
//   Holds in-flight branch predictions in program order. When the oldest branch
//   resolves, the queue issues a registered training update (pc, outcome) to the
//   BHT, flags a mispredict, discards all younger (wrong-path) entries on a
//   mispredict and keeps saturating accuracy statistics.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   pred_valid/pred_pc/pred_taken   prediction from the BHT
//   pred_ready                      queue can accept a prediction (occupancy < DEPTH)
//   res_valid/res_taken             outcome of the oldest outstanding branch
//   upd_valid/upd_pc/upd_taken      registered BHT training update
//   mispredict                      registered one-cycle pulse on a wrong prediction
//   occupancy                       entries currently held
//   underflow_err                   sticky: resolve seen while the queue was empty
//   total_count/correct_count       saturating resolve statistics

module branch_resolve_queue #(
  parameter int PC_W  = 9,
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pred_valid,
  input  logic [PC_W-1:0]            pred_pc,
  input  logic                       pred_taken,
  output logic                       pred_ready,
  input  logic                       res_valid,
  input  logic                       res_taken,
  output logic                       upd_valid,
  output logic [PC_W-1:0]            upd_pc,
  output logic                       upd_taken,
  output logic                       mispredict,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       underflow_err,
  output logic [CNT_W-1:0]           total_count,
  output logic [CNT_W-1:0]           correct_count
);

  localparam int AW = $clog2(DEPTH);

  // Queue storage; contents need no reset because occupancy gates every read.
  logic [PC_W-1:0] r_mem_pc    [DEPTH];
  logic            r_mem_taken [DEPTH];

  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_occ;

  logic            w_empty;
  logic            w_do_res;
  logic            w_head_taken;
  logic [PC_W-1:0] w_head_pc;
  logic            w_mis;
  logic            w_do_enq;
  logic [AW:0]     w_occ_next;

  // occupancy never exceeds DEPTH (a power of two), so the MSB alone marks full.
  // This keeps pred_ready purely registered with no path from res_valid.
  assign pred_ready   = ~r_occ[AW];
  assign occupancy    = r_occ;
  assign w_empty      = (r_occ == '0);

  assign w_head_pc    = r_mem_pc[r_rd_ptr];
  assign w_head_taken = r_mem_taken[r_rd_ptr];

  // A resolve on an empty queue is ignored; no bypass from a same-cycle enqueue.
  assign w_do_res     = res_valid & ~w_empty;
  assign w_mis        = w_do_res & (w_head_taken != res_taken);

  // An enqueue racing a mispredict belongs to the wrong path and is dropped.
  assign w_do_enq     = pred_valid & pred_ready & ~w_mis;

  always_comb begin
    w_occ_next = r_occ;
    if (w_mis) begin
      w_occ_next = '0;
    end else begin
      case ({w_do_enq, w_do_res})
        2'b10:   w_occ_next = r_occ + 1'b1;
        2'b01:   w_occ_next = r_occ - 1'b1;
        default: w_occ_next = r_occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_enq) begin
      r_mem_pc[r_wr_ptr]    <= pred_pc;
      r_mem_taken[r_wr_ptr] <= pred_taken;
    end
  end

  // Pointers wrap naturally at DEPTH because they are exactly AW bits wide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      r_occ <= w_occ_next;
      if (w_do_enq) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_mis) begin
        // Flush: everything younger than the mispredicted branch is discarded.
        r_rd_ptr <= r_wr_ptr;
      end else if (w_do_res) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upd_valid  <= 1'b0;
      upd_pc     <= '0;
      upd_taken  <= 1'b0;
      mispredict <= 1'b0;
    end else begin
      upd_valid  <= w_do_res;
      mispredict <= w_mis;
      if (w_do_res) begin
        upd_pc    <= w_head_pc;
        upd_taken <= res_taken;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underflow_err <= 1'b0;
    end else if (res_valid & w_empty) begin
      underflow_err <= 1'b1;
    end
  end

  // Statistics hold at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      total_count   <= '0;
      correct_count <= '0;
    end else if (w_do_res) begin
      if (~&total_count) begin
        total_count <= total_count + 1'b1;
      end
      if (~w_mis && ~&correct_count) begin
        correct_count <= correct_count + 1'b1;
      end
    end
  end

endmodule
